axi_mem_responder: RTL
======================

# axi_mem_responder

Single-beat AXI4 slave that terminates the CPU-side instruction or data AXI master and serves it from an internal word-addressed RAM. One instance sits behind each master port (inst: read channels only used; mem: all five channels) in simulation and on the FPGA evaluation platform. It has independent read and write engines, a programmable read latency, and out-of-order arrival of AW/W. Each engine carries one transaction in flight.

## Interface
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS_LOG2, 14, RAM depth = 2^MEM_WORDS_LOG2 32-bit words
- RD_LATENCY, 2, extra idle cycles between AR accept and rvalid (0..15)
- cpu_clk  in  1  clock
- cpu_reset  in  1  reset, asynchronous, active-high
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_arsize, s_arburst, s_arlen  in  3, 2, 8  checked only under the macro
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- s_rlast  out  1  equals s_rvalid
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_awsize, s_awburst, s_awlen  in  3, 2, 8  checked only under the macro
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_wlast  in  1  ignored
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake

## Operation
- Word index is addr[MEM_WORDS_LOG2+1:2]. addr[1:0] is ignored, and upper bits wrap modulo depth.
- Read FSM has three states:
  - R_IDLE: arready=1. On arvalid&arready, latch the index, load the counter with RD_LATENCY, and go to R_WAIT. If RD_LATENCY=0, go straight to R_DATA.
  - R_WAIT: decrement the counter. At 0, sample the RAM into rdata and go to R_DATA.
  - R_DATA: rvalid=1 and rdata is held stable. On rready, return to R_IDLE.
- Write FSM has three states:
  - W_COLLECT: awready=~aw_held and wready=~w_held. Each handshake latches its channel and sets its held flag. AW and W may arrive in any order or in the same cycle. When both flags are set, go to W_COMMIT.
  - W_COMMIT: one cycle. Write to the RAM with byte enables from wstrb (wstrb=0 writes nothing), then go to W_RESP.
  - W_RESP: bvalid=1. On bready, clear both flags and return to W_COLLECT.
- The read and write engines run fully independently. There is no address-hazard interlock: a RAM write committing on the same edge as a read sample returns the old data.
- The RAM has no reset. Its contents survive cpu_reset.

## Timing
- Reset values: every ready, rvalid, bvalid and rlast = 0; rdata = 0; rresp = bresp = 2'b00. Both FSMs return to idle and both held flags clear.
- arready, awready and wready go high in the first cycle after cpu_reset deasserts.
- Reset asserted mid-transaction drops any pending rvalid/bvalid asynchronously and discards the latched request.
- Read:
  - AR accepted in cycle T → rvalid from cycle T+1+RD_LATENCY.
  - R accepted in cycle U → arready high again in U+1.
  - Best-case read throughput is one beat per 2+RD_LATENCY cycles.
- Write:
  - Last of AW/W accepted in cycle C → RAM written at the end of C+1, bvalid from C+2.
  - B accepted in cycle U → awready and wready high in U+1.
- Once valid is raised, rvalid/bvalid stay high with stable payload until their handshake completes (AXI rule).

## Configuration
- AXI_MEM_RESP_CHECK_EN
  - Defined:
    - A read with arlen≠0, arsize≠3'b010, arburst≠2'b01, or addr ≥ 4·2^MEM_WORDS_LOG2 completes with rresp=2'b10 (SLVERR) and rdata=0.
    - The same violations on AW give bresp=2'b10, and W_COMMIT skips the RAM write.
    - No address wrap is applied in either case.
  - Undefined:
    - The size/burst/len inputs are unused.
    - The response is always 2'b00 and addresses wrap.

## Structure
- Package axi_mem_pkg holds:
  - the read and write FSM state enums
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - SIZE_WORD=3'b010, BURST_INCR=2'b01
- Sub-module axi_mem_ram: simple dual-port RAM with one synchronous read port and one byte-enabled write port. It has no reset and can be inferred as BRAM.
- The FSMs and handshake registers live in axi_mem_responder.

## Test plan
- RD_LATENCY=2. Reset, then AR addr 0x10 in cycle 5 → rvalid in cycle 8 with rdata equal to the preloaded word 4, rlast=1, rresp=0. Hold rready=0 for 3 cycles → rdata stable, arready stays 0.
- W (data 0xA5A5A5A5, strb 4'b0011) in cycle 3, AW addr 0x20 in cycle 6 → RAM word 8 = {old[31:16], 16'hA5A5}, bvalid in cycle 8. A read of 0x20 after B returns the merged value.
- AW and W in the same cycle while a read of the same word is in R_WAIT, with the commit edge equal to the read-sample edge → read returns the old value, B returns OKAY.
- Assert cpu_reset while rvalid=1 and aw_held=1 → rvalid and all readies drop immediately. After release, a fresh write/read pair completes normally and the RAM retains its prior contents.
- With AXI_MEM_RESP_CHECK_EN: AR with arlen=3 → rresp=2'b10, rdata=0. AW to addr 0x40000 → bresp=2'b10 and RAM word 0 is unchanged. Without the macro, the same AW writes word 0.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types and AXI encodings for the single-beat AXI memory responder.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port word RAM: one synchronous read port, one byte-enabled write port.
// No reset; a read and a write on the same word in the same cycle return the old data.
module axi_mem_ram #(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [3:0]           wr_be,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [31:0]          wr_data
);

  logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// Single-beat AXI4 slave serving an internal word RAM with independent read/write engines.
// Optional request checking (SLVERR on illegal size/burst/len/address) under AXI_MEM_RESP_CHECK_EN.
import axi_mem_pkg::*;

module axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 14,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic [7:0]            s_arlen,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  s_rlast,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic [7:0]            s_awlen,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready
);

  localparam int unsigned IW = MEM_WORDS_LOG2;

  rd_state_t      r_state, r_next;
  wr_state_t      w_state, w_next;
  logic           live;
  logic [3:0]     r_cnt;
  logic [IW-1:0]  r_idx;
  logic           r_err;
  logic           aw_held, w_held;
  logic [IW-1:0]  aw_idx;
  logic           aw_err;
  logic [31:0]    w_data;
  logic [3:0]     w_strb;

  logic           ar_hs, aw_hs, w_hs, b_hs;
  logic [IW-1:0]  ar_idx_in, aw_idx_in;
  logic           ar_err_in, aw_err_in;
  logic           ram_rd_en, ram_wr_en;
  logic [IW-1:0]  ram_rd_addr;
  logic [31:0]    ram_q;

  assign ar_hs = s_arvalid & s_arready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  assign ar_idx_in = s_araddr[IW+1:2];
  assign aw_idx_in = s_awaddr[IW+1:2];

`ifdef AXI_MEM_RESP_CHECK_EN
  assign ar_err_in = (s_arlen != 8'd0) | (s_arsize != SIZE_WORD) | (s_arburst != BURST_INCR)
                   | (s_araddr[ADDR_WIDTH-1:IW+2] != '0);
  assign aw_err_in = (s_awlen != 8'd0) | (s_awsize != SIZE_WORD) | (s_awburst != BURST_INCR)
                   | (s_awaddr[ADDR_WIDTH-1:IW+2] != '0);
  logic unused_bits;
  assign unused_bits = ^{s_araddr[1:0], s_awaddr[1:0], s_wlast};
`else
  assign ar_err_in = 1'b0;
  assign aw_err_in = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{s_araddr[ADDR_WIDTH-1:IW+2], s_araddr[1:0],
                         s_awaddr[ADDR_WIDTH-1:IW+2], s_awaddr[1:0],
                         s_arsize, s_arburst, s_arlen, s_awsize, s_awburst, s_awlen, s_wlast};
`endif

  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) live <= 1'b0;
    else           live <= 1'b1;
  end

  // ---------------- read engine ----------------
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT: if (r_cnt == 4'd1) r_next = R_DATA;
      R_DATA: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = live & (r_state == R_IDLE);
    s_rvalid  = (r_state == R_DATA);
    s_rlast   = s_rvalid;
    s_rresp   = (s_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    s_rdata   = (s_rvalid && !r_err) ? ram_q : '0;
  end

  // Counter holds the remaining wait cycles; the RAM sample is issued in the last one.
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (ar_hs) begin
      r_cnt <= 4'(RD_LATENCY);
      r_idx <= ar_idx_in;
      r_err <= ar_err_in;
    end else if (r_state == R_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    ram_rd_en   = (r_state == R_WAIT) && (r_cnt == 4'd1);
    ram_rd_addr = r_idx;
    if (RD_LATENCY == 0 && ar_hs) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = ar_idx_in;
    end
  end

  // ---------------- write engine ----------------
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) w_state <= W_COLLECT;
    else           w_state <= w_next;
  end

  // Commit follows the cycle in which the second of AW/W is accepted.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_COLLECT: if ((aw_held | aw_hs) & (w_held | w_hs)) w_next = W_COMMIT;
      W_COMMIT:  w_next = W_RESP;
      W_RESP:    if (s_bready) w_next = W_COLLECT;
      default:   w_next = W_COLLECT;
    endcase
  end

  always_comb begin
    s_awready = live & (w_state == W_COLLECT) & ~aw_held;
    s_wready  = live & (w_state == W_COLLECT) & ~w_held;
    s_bvalid  = (w_state == W_RESP);
    s_bresp   = (s_bvalid && aw_err) ? RESP_SLVERR : RESP_OKAY;
    ram_wr_en = (w_state == W_COMMIT) & ~aw_err;
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      aw_err  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= aw_idx_in;
        aw_err  <= aw_err_in;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  axi_mem_ram #(
    .ADDR_BITS(IW)
  ) u_ram (
    .clk    (cpu_clk),
    .rd_en  (ram_rd_en),
    .rd_addr(ram_rd_addr),
    .rd_data(ram_q),
    .wr_en  (ram_wr_en),
    .wr_be  (w_strb),
    .wr_addr(aw_idx),
    .wr_data(w_data)
  );

endmodule
